voice_allocator: RTL and testbench
==================================

# voice_allocator

Polyphonic voice allocator for the synth. Consumes raw PS/2 scan-code bytes from the keyboard receiver, tracks make/break sequences, maps keys to 5-bit note codes and assigns each held note to one of NUM_VOICES tone-generator voices. When all voices are busy, a new note steals a voice round-robin. Sits between the PS/2 byte receiver and the per-voice oscillator/envelope bank.

## Interface

**Parameters**
- `NUM_VOICES`, default 4: number of voices; range 2–8.

**Ports**
- `clock` in 1: system clock (50 MHz).
- `reset` in 1: asynchronous, active-high reset.
- `data_in` in 8: received scan-code byte.
- `data_in_enable` in 1: one-cycle strobe; `data_in` is valid in this cycle.
- `voice_note` out 5*NUM_VOICES: note code of voice i in bits [5i+4:5i]. Code 0 means no note.
- `voice_active` out NUM_VOICES: voice i is holding a pressed key.
- `voice_trigger` out NUM_VOICES: one-cycle pulse when voice i receives a new note, including on a steal.
- `steal` out 1: one-cycle pulse when the allocation evicted an active voice.

## Operation

**Note map.** The map is fixed in the package. Scan codes map to note codes as follows:
- 1A→1, 1B→2, 22→3, 23→4, 21→5, 2A→6, 34→7, 32→8, 33→9
- 31→10, 3B→11, 3A→12, 15→13, 1E→14, 1D→15, 26→16, 24→17
- 2D→18, 2E→19, 2C→20, 36→21, 35→22, 3D→23, 3C→24, 43→25
- Every other code maps to note 0.

**Prefix FSM.** The FSM advances only on `data_in_enable`.
- IDLE:
  - F0 → BRK.
  - E0 → EXT.
  - Any other byte is a make code; process it, then stay in IDLE.
- BRK: the byte is a break code; process it, then → IDLE.
- EXT:
  - F0 → EXT_BRK.
  - Any other byte is ignored → IDLE.
- EXT_BRK: the byte is ignored → IDLE.

**Make of note n.** If n = 0, do nothing. Otherwise, in priority order:
1. If an active voice already holds n, do nothing. This absorbs typematic repeat; no trigger is issued.
2. Otherwise, if any voice is inactive, assign n to the lowest-index inactive voice. Set it active and pulse its trigger.
3. Otherwise, assign n to voice `steal_ptr`. Pulse its trigger and pulse `steal`. Then advance `steal_ptr` by 1, wrapping from NUM_VOICES-1 to 0.

**Break of note n.**
- Every active voice holding n becomes inactive. At most one can, by construction.
- Its `voice_note` is held at its last value, so the envelope release phase can use it.
- A break for an unheld or zero note does nothing.

**Reset values.**
- State IDLE.
- `steal_ptr` = 0.
- All `voice_note` = 0.
- All `voice_active`, `voice_trigger` and `steal` = 0.

## Timing

- Strobe in cycle N → `voice_note`, `voice_active`, `voice_trigger` and `steal` updated at the clock edge ending cycle N; they are visible in cycle N+1.
- The trigger and steal pulses last exactly one cycle.
- There is no backpressure. Each strobe is fully processed in one cycle, and back-to-back strobes are legal.
- `data_in` is ignored when `data_in_enable` = 0; the FSM and all voice state hold.
- Asserting `reset` mid-sequence (for example, after F0) clears immediately without waiting for the clock. The next byte is interpreted from IDLE.
- Prefix bytes (F0, E0) produce no output change in the cycle after them.

## Structure

- Package `synth_pkg`:
  - `NOTE_W` = 5.
  - Constants `SC_BREAK` = 8'hF0 and `SC_EXT` = 8'hE0.
  - FSM state enum {IDLE, BRK, EXT, EXT_BRK}.
  - Function `scan_to_note(8-bit) → 5-bit` implementing the map.
- One sub-module, `voice_match`: purely combinational. Given the note array, the active vector and note n, it outputs:
  - `hit` and `hit_idx`: an active voice holds n.
  - `free` and `free_idx`: the lowest-index inactive voice.
- Top level holds the FSM, `steal_ptr` and the voice registers.

## Test plan

- **Reset:** assert `reset` asynchronously mid-cycle → all outputs 0, `steal_ptr` = 0.
- **Single press/release:** bytes 1A, F0, 1A →
  - cycle after 1A: `voice_note[0]` = 1, `voice_active` = 0001, `voice_trigger` = 0001;
  - after the F0 byte: no change;
  - after the final 1A: `voice_active` = 0000, `voice_note[0]` still 1.
- **Typematic and fill (NUM_VOICES = 4):** make codes 1A, 1A, 1B, 22, 23 → voices 0–3 hold notes 1, 2, 3, 4; only four trigger pulses; no `steal`.
- **Steal wrap:** with all 4 voices held, make 21, 2A, 34, 32, 33 →
  - voices 0, 1, 2, 3, 0 receive notes 5, 6, 7, 8, 9 in turn;
  - `steal` pulses 5 times;
  - `steal_ptr` ends at 1.
- **Extended and unmapped codes:** bytes E0, 1A, then E0, F0, 1A, then make 5A → no voice change; FSM returns to IDLE after each sequence. A following 1A allocates voice 0.
- **Reset mid-sequence and free-slot reuse:**
  - F0, then `reset`, then 1A → 1A is treated as a make and voice 0 gets note 1.
  - Separately, hold notes 1, 2, 3, release 2, then make 1B → voice 1 is reused.

Source files
------------

// File: rtl/synth_pkg.sv
// synth_pkg
// Shared definitions for the voice allocator: note-code width, the PS/2
// prefix bytes, the prefix-FSM state type and the fixed scan-code to
// note-code map.
package synth_pkg;

    localparam int NOTE_W = 5;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    // Unmapped scan codes return 0, which means "no note".
    function automatic logic [NOTE_W-1:0] scan_to_note(input logic [7:0] sc);
        logic [NOTE_W-1:0] n;
        case (sc)
            8'h1A:   n = 5'd1;
            8'h1B:   n = 5'd2;
            8'h22:   n = 5'd3;
            8'h23:   n = 5'd4;
            8'h21:   n = 5'd5;
            8'h2A:   n = 5'd6;
            8'h34:   n = 5'd7;
            8'h32:   n = 5'd8;
            8'h33:   n = 5'd9;
            8'h31:   n = 5'd10;
            8'h3B:   n = 5'd11;
            8'h3A:   n = 5'd12;
            8'h15:   n = 5'd13;
            8'h1E:   n = 5'd14;
            8'h1D:   n = 5'd15;
            8'h26:   n = 5'd16;
            8'h24:   n = 5'd17;
            8'h2D:   n = 5'd18;
            8'h2E:   n = 5'd19;
            8'h2C:   n = 5'd20;
            8'h36:   n = 5'd21;
            8'h35:   n = 5'd22;
            8'h3D:   n = 5'd23;
            8'h3C:   n = 5'd24;
            8'h43:   n = 5'd25;
            default: n = 5'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/voice_allocator_voice_match.sv
// voice_match
// Purely combinational voice lookup.
//   notes_i    : packed note codes, voice i in bits [5i+4:5i]
//   active_i   : per-voice active flags
//   note_i     : note being searched for
//   hit_o      : some active voice holds note_i
//   hit_idx_o  : index of that voice
//   free_o     : at least one voice is inactive
//   free_idx_o : lowest-index inactive voice
module voice_match
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic [NUM_VOICES*NOTE_W-1:0] notes_i,
    input  logic [NUM_VOICES-1:0]        active_i,
    input  logic [NOTE_W-1:0]            note_i,
    output logic                         hit_o,
    output logic [IDX_W-1:0]             hit_idx_o,
    output logic                         free_o,
    output logic [IDX_W-1:0]             free_idx_o
);

    always_comb begin
        hit_o      = 1'b0;
        hit_idx_o  = '0;
        free_o     = 1'b0;
        free_idx_o = '0;
        // Scan from the top down so the lowest matching index is the last
        // one written and therefore wins.
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (active_i[i] && (notes_i[i*NOTE_W +: NOTE_W] == note_i)) begin
                hit_o     = 1'b1;
                hit_idx_o = IDX_W'(i);
            end
            if (!active_i[i]) begin
                free_o     = 1'b1;
                free_idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator
// Polyphonic voice allocator. Decodes PS/2 make/break byte sequences,
// maps keys to note codes and assigns held notes to voices, stealing
// round-robin when every voice is busy.
//   clock          : system clock
//   reset          : asynchronous active-high reset
//   data_in        : received scan-code byte
//   data_in_enable : one-cycle strobe qualifying data_in
//   voice_note     : note code per voice, voice i in bits [5i+4:5i]
//   voice_active   : voice i is holding a pressed key
//   voice_trigger  : one-cycle pulse when voice i takes a new note
//   steal          : one-cycle pulse when an active voice was evicted
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [7:0]                   data_in,
    input  logic                         data_in_enable,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic [NUM_VOICES-1:0]        voice_trigger,
    output logic                         steal
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    state_t                        state_q;
    logic [IDX_W-1:0]              steal_ptr_q;
    logic [NUM_VOICES*NOTE_W-1:0]  note_q;
    logic [NUM_VOICES-1:0]         active_q;
    logic [NUM_VOICES-1:0]         trigger_q;
    logic                          steal_q;

    logic [NOTE_W-1:0] byte_note;
    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic              free;
    logic [IDX_W-1:0]  free_idx;

    assign byte_note = scan_to_note(data_in);

    voice_match #(
        .NUM_VOICES (NUM_VOICES),
        .IDX_W      (IDX_W)
    ) u_match (
        .notes_i    (note_q),
        .active_i   (active_q),
        .note_i     (byte_note),
        .hit_o      (hit),
        .hit_idx_o  (hit_idx),
        .free_o     (free),
        .free_idx_o (free_idx)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            steal_ptr_q <= '0;
            note_q      <= '0;
            active_q    <= '0;
            trigger_q   <= '0;
            steal_q     <= 1'b0;
        end else begin
            trigger_q <= '0;
            steal_q   <= 1'b0;
            if (data_in_enable) begin
                case (state_q)
                    IDLE: begin
                        if (data_in == SC_BREAK) begin
                            state_q <= BRK;
                        end else if (data_in == SC_EXT) begin
                            state_q <= EXT;
                        end else if ((byte_note != '0) && !hit) begin
                            // A hit means typematic repeat of a held key.
                            if (free) begin
                                note_q[free_idx*NOTE_W +: NOTE_W] <= byte_note;
                                active_q[free_idx]  <= 1'b1;
                                trigger_q[free_idx] <= 1'b1;
                            end else begin
                                note_q[steal_ptr_q*NOTE_W +: NOTE_W] <= byte_note;
                                trigger_q[steal_ptr_q] <= 1'b1;
                                steal_q     <= 1'b1;
                                steal_ptr_q <= (steal_ptr_q == LAST_IDX) ? '0
                                                                         : steal_ptr_q + 1'b1;
                            end
                        end
                    end
                    BRK: begin
                        // The note code is kept so the release envelope can use it.
                        if ((byte_note != '0) && hit) begin
                            active_q[hit_idx] <= 1'b0;
                        end
                        state_q <= IDLE;
                    end
                    EXT: begin
                        state_q <= (data_in == SC_BREAK) ? EXT_BRK : IDLE;
                    end
                    EXT_BRK: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign voice_note    = note_q;
    assign voice_active  = active_q;
    assign voice_trigger = trigger_q;
    assign steal         = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator
// Directed scenarios followed by random byte streams, checked against a
// behavioural model of the allocation rules.
module tb_voice_allocator;

    localparam int NV = 4;

    localparam logic [7:0] SC_TAB [25] = '{
        8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34, 8'h32, 8'h33,
        8'h31, 8'h3B, 8'h3A, 8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24,
        8'h2D, 8'h2E, 8'h2C, 8'h36, 8'h35, 8'h3D, 8'h3C, 8'h43
    };

    logic              clock = 1'b0;
    logic              reset;
    logic [7:0]        data_in;
    logic              data_in_enable;
    logic [5*NV-1:0]   voice_note;
    logic [NV-1:0]     voice_active;
    logic [NV-1:0]     voice_trigger;
    logic              steal;

    voice_allocator #(.NUM_VOICES(NV)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_in        (data_in),
        .data_in_enable (data_in_enable),
        .voice_note     (voice_note),
        .voice_active   (voice_active),
        .voice_trigger  (voice_trigger),
        .steal          (steal)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: plain arrays and an integer prefix mode.
    int            m_note [NV];
    bit            m_act  [NV];
    int            m_ptr;
    int            m_mode;   // 0 none, 1 after F0, 2 after E0, 3 after E0 F0
    logic [NV-1:0] m_trig;
    bit            m_steal;

    int trig_count;
    int steal_count;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int map_note(input logic [7:0] b);
        for (int k = 0; k < 25; k++)
            if (SC_TAB[k] == b) return k + 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_note[i] = 0;
            m_act[i]  = 1'b0;
        end
        m_ptr   = 0;
        m_mode  = 0;
        m_trig  = '0;
        m_steal = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int  n;
        bit  held;
        int  slot;
        m_trig  = '0;
        m_steal = 1'b0;
        n = map_note(b);
        if (m_mode == 0) begin
            if (b == 8'hF0) m_mode = 1;
            else if (b == 8'hE0) m_mode = 2;
            else if (n != 0) begin
                held = 1'b0;
                for (int i = 0; i < NV; i++)
                    if (m_act[i] && m_note[i] == n) held = 1'b1;
                if (!held) begin
                    slot = -1;
                    for (int i = 0; i < NV; i++)
                        if (!m_act[i] && slot < 0) slot = i;
                    if (slot >= 0) begin
                        m_note[slot] = n;
                        m_act[slot]  = 1'b1;
                        m_trig[slot] = 1'b1;
                    end else begin
                        m_note[m_ptr] = n;
                        m_trig[m_ptr] = 1'b1;
                        m_steal       = 1'b1;
                        m_ptr         = (m_ptr + 1) % NV;
                    end
                end
            end
        end else if (m_mode == 1) begin
            if (n != 0)
                for (int i = 0; i < NV; i++)
                    if (m_act[i] && m_note[i] == n) m_act[i] = 1'b0;
            m_mode = 0;
        end else if (m_mode == 2) begin
            m_mode = (b == 8'hF0) ? 3 : 0;
        end else begin
            m_mode = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [5*NV-1:0] en;
        logic [NV-1:0]   ea;
        for (int i = 0; i < NV; i++) begin
            en[i*5 +: 5] = 5'(m_note[i]);
            ea[i]        = m_act[i];
        end
        chk({tag, "/note"},    32'(voice_note),    32'(en));
        chk({tag, "/active"},  32'(voice_active),  32'(ea));
        chk({tag, "/trigger"}, 32'(voice_trigger), 32'(m_trig));
        chk({tag, "/steal"},   32'(steal),         32'(m_steal));
    endtask

    task automatic send(input logic [7:0] b);
        data_in        = b;
        data_in_enable = 1'b1;
        @(posedge clock);
        #1;
        data_in_enable = 1'b0;
        data_in        = 8'($urandom);
        model_byte(b);
        check_outputs("byte");
        trig_count  += $countones(voice_trigger);
        steal_count += int'(steal);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            m_trig  = '0;
            m_steal = 1'b0;
            check_outputs("idle");
        end
    endtask

    // Reset lands mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("rst");
        chk("rst/steal_ptr", 32'(dut.steal_ptr_q), 32'(m_ptr));
        @(posedge clock);
        #1;
        reset = 1'b0;
        trig_count  = 0;
        steal_count = 0;
    endtask

    logic [7:0] rb;

    initial begin
        reset          = 1'b1;
        data_in        = 8'h00;
        data_in_enable = 1'b0;
        trig_count     = 0;
        steal_count    = 0;
        model_reset();
        @(posedge clock);
        #1;
        do_reset();

        // Single press / release
        send(8'h1A);
        chk("single/note0",  32'(voice_note[4:0]), 32'd1);
        chk("single/active", 32'(voice_active),    32'b0001);
        chk("single/trig",   32'(voice_trigger),   32'b0001);
        send(8'hF0);
        chk("single/f0_active", 32'(voice_active),  32'b0001);
        chk("single/f0_trig",   32'(voice_trigger), 32'b0000);
        send(8'h1A);
        chk("single/rel_active", 32'(voice_active),    32'b0000);
        chk("single/rel_note0",  32'(voice_note[4:0]), 32'd1);
        idle(2);

        // Typematic repeat and fill
        do_reset();
        send(8'h1A); send(8'h1A); send(8'h1B); send(8'h22); send(8'h23);
        chk("fill/notes",   32'(voice_note),   32'({5'd4, 5'd3, 5'd2, 5'd1}));
        chk("fill/active",  32'(voice_active), 32'b1111);
        chk("fill/trigs",   32'(trig_count),   32'd4);
        chk("fill/steals",  32'(steal_count),  32'd0);

        // Steal wrap
        send(8'h21); send(8'h2A); send(8'h34); send(8'h32); send(8'h33);
        chk("steal/notes",  32'(voice_note),       32'({5'd8, 5'd7, 5'd6, 5'd9}));
        chk("steal/steals", 32'(steal_count),      32'd5);
        chk("steal/ptr",    32'(dut.steal_ptr_q),  32'd1);
        idle(1);

        // Extended and unmapped codes
        do_reset();
        send(8'hE0); send(8'h1A);
        send(8'hE0); send(8'hF0); send(8'h1A);
        send(8'h5A);
        chk("ext/active", 32'(voice_active), 32'b0000);
        chk("ext/trigs",  32'(trig_count),   32'd0);
        send(8'h1A);
        chk("ext/after_trig", 32'(voice_trigger),   32'b0001);
        chk("ext/after_note", 32'(voice_note[4:0]), 32'd1);

        // Reset mid-sequence
        do_reset();
        send(8'hF0);
        do_reset();
        send(8'h1A);
        chk("midrst/active", 32'(voice_active),    32'b0001);
        chk("midrst/note0",  32'(voice_note[4:0]), 32'd1);

        // Free-slot reuse
        do_reset();
        send(8'h1A); send(8'h1B); send(8'h22);
        send(8'hF0); send(8'h1B);
        chk("reuse/active_rel", 32'(voice_active), 32'b0101);
        send(8'h1B);
        chk("reuse/trig",   32'(voice_trigger), 32'b0010);
        chk("reuse/active", 32'(voice_active),  32'b0111);
        chk("reuse/note1",  32'(voice_note[9:5]), 32'd2);

        // Random byte stream
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            case ($urandom_range(0, 9))
                0, 1:    rb = 8'hF0;
                2:       rb = 8'hE0;
                3:       rb = 8'($urandom);
                default: rb = SC_TAB[$urandom_range(0, 8)];
            endcase
            send(rb);
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 2));
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
